// File: rtl/adder_result_fifo.sv
// adder_result_fifo: FWFT result FIFO capturing adder sum/cout with ovf/zero/neg flags
// Define ADDER_RESULT_STICKY_OVF_EN to enable the sticky overflow flag.
module adder_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] count,
  input  logic             clr_sticky,
  output logic             ovf_sticky
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH+3:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic push, pop, ovf;
  assign in_ready = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
  // Empty FIFO forces all head fields to zero rather than exposing stale storage.
  assign {out_cout, out_ovf, out_zero, out_neg, out_sum} = out_valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {cout, ovf, sum == '0, sum[WIDTH-1], sum};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
`ifdef ADDER_RESULT_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (push && ovf) ovf_sticky <= 1'b1;
    else if (clr_sticky) ovf_sticky <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_adder_result_fifo.sv
// tb_adder_result_fifo: randomized scoreboard bench for adder_result_fifo
// Reference model is a queue of entries with flags derived from the sign/zero rules.
module tb_adder_result_fifo;
  logic clk = 0;
  logic rst, in_valid, in_ready, a_msb, b_msb, cout, out_valid, out_ready;
  logic out_cout, out_ovf, out_zero, out_neg, clr_sticky, ovf_sticky;
  logic [31:0] sum, out_sum;
  logic [2:0] count;
  typedef struct {logic [31:0] s; logic c, o, z, n;} ent_t;
  ent_t q[$];
  bit sticky = 0;
  bit started = 0;
  int passed = 0, total = 0;

  adder_result_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_msb(a_msb), .b_msb(b_msb), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
    .count(count), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accepts on the edge when the queue has room, pops when non-empty.
  always @(posedge clk) begin
    ent_t e;
    bit ps, pp;
    if (rst) begin
      q.delete();
      sticky = 0;
    end else begin
      ps = in_valid && q.size() < 4;
      pp = out_ready && q.size() > 0;
      e.s = sum;
      e.c = cout;
      e.o = (a_msb == b_msb) && (sum[31] != a_msb);
      e.z = (sum == 0);
      e.n = sum[31];
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(e);
      if (ps && e.o) sticky = 1;
      else if (clr_sticky) sticky = 0;
    end
  end

  always @(negedge clk) if (started) begin
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != 4));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_sum", 64'(out_sum), 64'(q[0].s));
      chk("out_cout", 64'(out_cout), 64'(q[0].c));
      chk("out_ovf", 64'(out_ovf), 64'(q[0].o));
      chk("out_zero", 64'(out_zero), 64'(q[0].z));
      chk("out_neg", 64'(out_neg), 64'(q[0].n));
    end else
      chk("empty_outs", 64'({out_sum, out_cout, out_ovf, out_zero, out_neg}), 64'(0));
`ifdef ADDER_RESULT_STICKY_OVF_EN
    chk("ovf_sticky", 64'(ovf_sticky), 64'(sticky));
`else
    chk("ovf_sticky", 64'(ovf_sticky), 64'(0));
`endif
  end

  task automatic step(bit v, bit am, bit bm, logic [31:0] s, bit c, bit r, bit cl = 0, bit rs = 0);
    @(negedge clk);
    #1;
    in_valid = v; a_msb = am; b_msb = bm; sum = s; cout = c;
    out_ready = r; clr_sticky = cl; rst = rs;
  endtask

  task automatic idle(int n, bit r);
    repeat (n) step(0, 0, 0, 32'h0, 0, r);
  endtask

  initial begin
    logic [31:0] s;
    rst = 1; in_valid = 0; a_msb = 0; b_msb = 0; sum = 0; cout = 0;
    out_ready = 0; clr_sticky = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    started = 1;
    idle(2, 0);
    step(1, 0, 0, 32'h8000_0000, 0, 0);
    idle(3, 0);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    idle(1, 0);
    idle(2, 1);
    step(1, 1, 1, 32'h7FFF_FFFF, 1, 1);
    step(1, 0, 1, 32'hFFFF_FF9C, 0, 1);
    step(1, 0, 0, 32'h0, 0, 1);
    idle(3, 1);
    step(1, 0, 0, 32'd150, 0, 0);
    step(1, 1, 0, -32'sd149, 0, 0);
    step(1, 1, 1, -32'sd4443, 1, 0);
    step(1, 0, 1, -32'sd4444, 0, 0);
    step(1, 0, 0, 32'd7, 0, 0);
    step(1, 0, 0, 32'd7, 0, 0);
    idle(6, 1);
    step(1, 0, 0, 32'd1, 0, 0);
    step(1, 0, 0, 32'd2, 0, 0);
    for (int i = 0; i < 6; i++) step(1, i[0], i[1], 32'd10 + i, i[2], 1);
    step(1, 0, 0, 32'd99, 0, 1, 0, 1);
    idle(2, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 4)
        0: s = 32'h0;
        1: s = 32'h8000_0000;
        2: s = 32'h7FFF_FFFF;
        default: s = $urandom;
      endcase
      step($urandom % 4 != 0, $urandom % 2 == 1, $urandom % 2 == 1, s, $urandom % 2 == 1,
           $urandom % 3 != 0, $urandom % 8 == 0, $urandom % 64 == 0);
    end
    idle(6, 1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
